// File: rtl/cga_text_fetch.sv
// cga_text_fetch
//   Text-mode pixel source for the cga colour stage. A pixel coordinate from the
//   VGA timing generator is mapped to a character cell. The {attr, char} word is
//   read from text RAM, then the glyph row is read from font ROM. The block
//   produces the IRGB colour pair and the per-pixel "on" bit, and adds attribute
//   blink and a hardware cursor bar.
//
//   Latency: color_o is valid 4 clocks after a pixel is sampled and on_o is valid
//   5 clocks after it. This one-cycle lead of color_o matches cga's colour register.
//
// Ports
//   clk_i, rstn_i          pixel clock, async active-low reset
//   x_i, y_i, de_i         pixel coordinate and display enable from the timing gen
//   frame_i                one-cycle pulse per frame (drives the blink timer)
//   cursor_en_i/col/row    cursor enable and cell position
//   text_addr_o/text_data_i  text RAM port, {attr, char}, 1-cycle read latency
//   font_addr_o/font_data_i  font ROM port, {char, glyph_line}, bit7 = leftmost px
//   color_o                {bg irgb, fg irgb} to cga
//   on_o                   pixel on to cga
module cga_text_fetch #(
  parameter int COLS      = 80,
  parameter int ROWS      = 30,
  parameter int CHAR_H    = 16,
  parameter int ADDR_W    = 12,
  parameter int BLINK_EN  = 1,
  parameter int BLINK_FR  = 16,
  parameter int CUR_START = 14,
  parameter int CUR_END   = 15
) (
  input  logic                            clk_i,
  input  logic                            rstn_i,
  input  logic [9:0]                      x_i,
  input  logic [9:0]                      y_i,
  input  logic                            de_i,
  input  logic                            frame_i,
  input  logic                            cursor_en_i,
  input  logic [6:0]                      cursor_col_i,
  input  logic [4:0]                      cursor_row_i,
  output logic [ADDR_W-1:0]               text_addr_o,
  input  logic [15:0]                     text_data_i,
  output logic [8+$clog2(CHAR_H)-1:0]     font_addr_o,
  input  logic [7:0]                      font_data_i,
  output logic [7:0]                      color_o,
  output logic                            on_o
);

  localparam int LW = $clog2(CHAR_H);
  localparam int RW = 10 - LW;
  localparam int BW = (BLINK_FR > 1) ? $clog2(BLINK_FR) : 1;
  localparam logic [ADDR_W-1:0] COLS_A     = ADDR_W'(COLS);
  localparam logic [BW-1:0]     BLINK_LAST = BW'(BLINK_FR - 1);

  logic [6:0]        col;
  logic [RW-1:0]     row;
  logic [LW-1:0]     line;
  logic              in_area;
  logic              cur_hit;
  logic [ADDR_W-1:0] cell_addr;

  // Pipeline stage registers; the suffix is the number of clocks after sampling.
  logic              valid_1, valid_2, valid_3, valid_4;
  logic [LW-1:0]     line_1, line_2;
  logic [2:0]        xlo_1, xlo_2, xlo_3, xlo_4;
  logic              cur_1, cur_2, cur_3, cur_4;
  logic [7:0]        attr_3;
  logic              blink_4;

  logic [BW-1:0]     blink_cnt;
  logic              phase;
  logic [7:0]        color_next;
  logic              glyph_bit;
  logic              on_next;

  assign col  = x_i[9:3];
  assign row  = y_i[9:LW];
  assign line = y_i[LW-1:0];

  // Cell decode at sample time. Pixels outside the text grid count as blank, and so
  // do pixels outside the active area. The cursor match uses the cursor inputs
  // sampled in the same cycle as x/y.
  always_comb begin
    in_area   = de_i && (32'(col) < COLS) && (32'(row) < ROWS);
    cur_hit   = cursor_en_i && (col == cursor_col_i) && (row == RW'(cursor_row_i)) &&
                (32'(line) >= CUR_START) && (32'(line) <= CUR_END);
    cell_addr = ADDR_W'(row) * COLS_A + ADDR_W'(col);
  end

  // Stage 1: text RAM address. Blank pixels park the address at 0.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      text_addr_o <= '0;
      valid_1     <= 1'b0;
      line_1      <= '0;
      xlo_1       <= '0;
      cur_1       <= 1'b0;
    end else begin
      text_addr_o <= in_area ? cell_addr : '0;
      valid_1     <= in_area;
      line_1      <= line;
      xlo_1       <= x_i[2:0];
      cur_1       <= cur_hit && in_area;
    end
  end

  // Stages 2-4: text data arrives at stage 2. The char then addresses the font ROM,
  // and the side-band bits are delayed so they line up with the font data.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      valid_2     <= 1'b0;
      line_2      <= '0;
      xlo_2       <= '0;
      cur_2       <= 1'b0;
      valid_3     <= 1'b0;
      font_addr_o <= '0;
      attr_3      <= '0;
      xlo_3       <= '0;
      cur_3       <= 1'b0;
      valid_4     <= 1'b0;
      xlo_4       <= '0;
      cur_4       <= 1'b0;
      blink_4     <= 1'b0;
    end else begin
      valid_2     <= valid_1;
      line_2      <= line_1;
      xlo_2       <= xlo_1;
      cur_2       <= cur_1;
      valid_3     <= valid_2;
      font_addr_o <= {text_data_i[7:0], line_2};
      attr_3      <= text_data_i[15:8];
      xlo_3       <= xlo_2;
      cur_3       <= cur_2;
      valid_4     <= valid_3;
      xlo_4       <= xlo_3;
      cur_4       <= cur_3;
      blink_4     <= attr_3[7];
    end
  end

  // Blink timer: counts frame pulses and flips the visible phase on each wrap.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      blink_cnt <= '0;
      phase     <= 1'b1;
    end else if (frame_i) begin
      if (blink_cnt == BLINK_LAST) begin
        blink_cnt <= '0;
        phase     <= ~phase;
      end else begin
        blink_cnt <= blink_cnt + 1'b1;
      end
    end
  end

  // Output selection. When blink is enabled, attr[7] is the blink flag rather than
  // background intensity, so it never reaches the colour. For the on bit, a blank
  // pixel beats the cursor, the cursor beats blink, and blink beats the glyph.
  always_comb begin
    color_next = (BLINK_EN != 0) ? {1'b0, attr_3[6:0]} : attr_3;
    glyph_bit  = font_data_i[3'd7 - xlo_4];
    on_next    = glyph_bit;
    if (!valid_4) begin
      on_next = 1'b0;
    end else if (cur_4 && phase) begin
      on_next = 1'b1;
    end else if ((BLINK_EN != 0) && blink_4 && !phase) begin
      on_next = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      color_o <= '0;
      on_o    <= 1'b0;
    end else begin
      color_o <= valid_3 ? color_next : 8'h00;
      on_o    <= on_next;
    end
  end

endmodule

// File: tb/tb_cga_text_fetch.sv
// tb_cga_text_fetch
//   Directed bench for cga_text_fetch (BLINK_FR overridden to 2). The bench models
//   the text RAM and the font ROM as 1-cycle memories. Each issued pixel pushes its
//   hand-computed address, colour and on values onto a scoreboard. A monitor then
//   compares them at 1, 4 and 5 clocks after issue.
module tb_cga_text_fetch;

  logic        clk = 1'b0;
  logic        rstn;
  logic [9:0]  x, y;
  logic        de, frame;
  logic        cursor_en;
  logic [6:0]  cursor_col;
  logic [4:0]  cursor_row;
  logic [11:0] text_addr;
  logic [15:0] text_data;
  logic [11:0] font_addr;
  logic [7:0]  font_data;
  logic [7:0]  color;
  logic        on;

  logic [15:0] tram [0:4095];
  logic [7:0]  from [0:4095];

  typedef struct {
    int          issue;
    logic [11:0] addr;
    logic [7:0]  color;
    logic        on;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  cga_text_fetch #(.BLINK_FR(2)) dut (
    .clk_i        (clk),
    .rstn_i       (rstn),
    .x_i          (x),
    .y_i          (y),
    .de_i         (de),
    .frame_i      (frame),
    .cursor_en_i  (cursor_en),
    .cursor_col_i (cursor_col),
    .cursor_row_i (cursor_row),
    .text_addr_o  (text_addr),
    .text_data_i  (text_data),
    .font_addr_o  (font_addr),
    .font_data_i  (font_data),
    .color_o      (color),
    .on_o         (on)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous memory models with one cycle of read latency.
  always @(posedge clk) begin
    text_data <= tram[text_addr];
    font_data <= from[font_addr];
  end

  // Monitor: compares each scoreboard entry when its value is due at the outputs.
  always @(negedge clk) begin
    for (int i = 0; i < sb.size(); i++) begin
      if (sb[i].issue + 1 == cyc) begin
        n_checks++;
        if (text_addr !== sb[i].addr) begin
          n_fail++;
          $display("[TB] FAIL %s text_addr: got %0d, expected %0d", sb[i].name, text_addr, sb[i].addr);
        end
      end
      if (sb[i].issue + 4 == cyc) begin
        n_checks++;
        if (color !== sb[i].color) begin
          n_fail++;
          $display("[TB] FAIL %s color: got %h, expected %h", sb[i].name, color, sb[i].color);
        end
      end
      if (sb[i].issue + 5 == cyc) begin
        n_checks++;
        if (on !== sb[i].on) begin
          n_fail++;
          $display("[TB] FAIL %s on: got %b, expected %b", sb[i].name, on, sb[i].on);
        end
      end
    end
    while (sb.size() > 0 && sb[0].issue + 5 <= cyc) sb.delete(0);
  end

  // Drives one pixel and records what the DUT must produce for it.
  task automatic apply_stimulus(input string name, input int px, input int py, input logic pde,
                                input int eaddr, input logic [7:0] ecol, input logic eon);
    exp_t e;
    @(negedge clk);
    x  = 10'(px);
    y  = 10'(py);
    de = pde;
    e.issue = cyc;
    e.addr  = 12'(eaddr);
    e.color = ecol;
    e.on    = eon;
    e.name  = name;
    sb.push_back(e);
  endtask

  task automatic check_output(input string name, input int got, input int expected);
    n_checks++;
    if (got !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, got, expected);
    end
  endtask

  // Blanks the inputs, then waits (bounded) until the scoreboard has drained.
  task automatic drain();
    int n = 0;
    @(negedge clk);
    de = 1'b0;
    x  = '0;
    y  = '0;
    while (sb.size() > 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() > 0) begin
      n_checks++;
      n_fail++;
      $display("[TB] FAIL drain: %0d entries left, expected 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic pulse_frame();
    @(negedge clk);
    frame = 1'b1;
    @(negedge clk);
    frame = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    int exp2 [8];
    int blink_exp [5];
    exp2      = '{0, 0, 0, 1, 1, 0, 0, 0};
    blink_exp = '{1, 1, 0, 0, 1};

    for (int i = 0; i < 4096; i++) begin
      tram[i] = 16'h0000;
      from[i] = 8'h00;
    end
    tram[0]    = {8'h1E, 8'h41};  from[{8'h41, 4'd0}] = 8'h18;
    tram[1]    = {8'h8F, 8'h43};  from[{8'h43, 4'd0}] = 8'hFF;
    tram[2399] = {8'h2A, 8'h42};  from[{8'h42, 4'd0}] = 8'hA5;
    tram[245]  = {8'h07, 8'h20};
    tram[160]  = {8'h07, 8'h44};  from[{8'h44, 4'd0}] = 8'hF0;
    tram[161]  = {8'h70, 8'h45};  from[{8'h45, 4'd0}] = 8'h0F;

    rstn = 1'b0; x = '0; y = '0; de = 1'b0; frame = 1'b0;
    cursor_en = 1'b0; cursor_col = 7'd5; cursor_row = 5'd3;

    repeat (3) @(negedge clk);
    check_output("reset color", int'(color), 0);
    check_output("reset on", int'(on), 0);
    check_output("reset text_addr", int'(text_addr), 0);
    rstn = 1'b1;

    // First cell: attribute 0x1E, glyph row 0x18.
    for (int i = 0; i < 8; i++)
      apply_stimulus("cell0", i, 0, 1'b1, 0, 8'h1E, exp2[i] != 0);
    drain();

    // Last cell of the grid, just past the right edge, de low, below the grid.
    apply_stimulus("last_cell", 632, 464, 1'b1, 2399, 8'h2A, 1'b1);
    apply_stimulus("last_cell_x639", 639, 464, 1'b1, 2399, 8'h2A, 1'b1);
    apply_stimulus("x640", 640, 464, 1'b1, 0, 8'h00, 1'b0);
    apply_stimulus("de0", 0, 0, 1'b0, 0, 8'h00, 1'b0);
    apply_stimulus("y480", 0, 480, 1'b1, 0, 8'h00, 1'b0);
    apply_stimulus("x633", 633, 464, 1'b1, 2399, 8'h2A, 1'b0);
    drain();

    // Blink, with a period of two frames.
    for (int f = 0; f < 5; f++) begin
      if (f > 0) pulse_frame();
      apply_stimulus("blink_x8", 8, 0, 1'b1, 1, 8'h0F, blink_exp[f] != 0);
      apply_stimulus("blink_x15", 15, 0, 1'b1, 1, 8'h0F, blink_exp[f] != 0);
      drain();
    end

    // Cursor bar at (5,3), glyph lines 14..15.
    cursor_en = 1'b1;
    for (int i = 0; i < 8; i++)
      apply_stimulus("cursor_on", 40 + i, 62, 1'b1, 245, 8'h07, 1'b1);
    apply_stimulus("cursor_line13", 40, 61, 1'b1, 245, 8'h07, 1'b0);
    apply_stimulus("cursor_line15", 47, 63, 1'b1, 245, 8'h07, 1'b1);
    apply_stimulus("cursor_col6", 48, 62, 1'b1, 246, 8'h00, 1'b0);
    drain();
    pulse_frame();
    pulse_frame();
    apply_stimulus("cursor_phase0", 40, 62, 1'b1, 245, 8'h07, 1'b0);
    apply_stimulus("cursor_phase0_x47", 47, 62, 1'b1, 245, 8'h07, 1'b0);
    apply_stimulus("blink_phase0", 8, 0, 1'b1, 1, 8'h0F, 1'b0);
    drain();

    // Asynchronous reset mid-line while the outputs are active; phase returns to visible.
    @(negedge clk);
    x = 10'd3; y = 10'd0; de = 1'b1;
    repeat (6) @(negedge clk);
    check_output("pre_reset color", int'(color), 'h1E);
    check_output("pre_reset on", int'(on), 1);
    @(posedge clk);
    #2 rstn = 1'b0;
    #1;
    check_output("async_reset color", int'(color), 0);
    check_output("async_reset on", int'(on), 0);
    check_output("async_reset text_addr", int'(text_addr), 0);
    @(negedge clk);
    de = 1'b0;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    apply_stimulus("blink_after_reset", 8, 0, 1'b1, 1, 8'h0F, 1'b1);
    apply_stimulus("cursor_after_reset", 41, 62, 1'b1, 245, 8'h07, 1'b1);
    drain();

    // Back-to-back cells with different attributes.
    cursor_en = 1'b0;
    for (int i = 0; i < 16; i++)
      apply_stimulus("b2b", i, 32, 1'b1, 160 + i / 8, (i < 8) ? 8'h07 : 8'h70, (i < 4) || (i >= 12));
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
